// File: rtl/rv_mc_control_if.sv
// rv_mc_control_if: bundle between the control sequencer, the IR/ALU flags,
// the instruction/data memory handshakes and the datapath enables.
interface rv_mc_control_if;
    logic [31:0] instr;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic        imem_req;
    logic        imem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic [2:0]  imm_type;
    logic        alu_src_b;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [2:0]  state_o;

    modport master (
        input  instr, zero, lt, ltu, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, imm_type,
               alu_src_b, alu_op, reg_we, wb_sel, trap, state_o
    );

    modport slave (
        output instr, zero, lt, ltu, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, imm_type,
               alu_src_b, alu_op, reg_we, wb_sel, trap, state_o
    );
endinterface

// File: rtl/rv_mc_control.sv
// rv_mc_control: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer driving the RV32I
// datapath enables, immediate select and memory handshakes, with a memory-wait watchdog.
module rv_mc_control #(
    parameter int WAIT_LIMIT = 16
) (
    input logic             clk,
    input logic             rst_n,
    rv_mc_control_if.master bus
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [8:0] LIMIT      = 9'(WAIT_LIMIT);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic [7:0] r_cnt;
    logic [2:0] w_f3;
    logic       w_ld, w_st, w_br, w_jal, w_jalr, w_lui, w_op, w_opi, w_legal;
    logic       w_wait, w_ready, w_timeout, w_taken, w_br_bad;
    logic       w_srcb;
    logic [3:0] w_aluop;
    logic [2:0] w_imm;

    assign w_f3    = bus.instr[14:12];
    assign w_ld    = bus.instr[6:0] == OPC_LOAD;
    assign w_st    = bus.instr[6:0] == OPC_STORE;
    assign w_br    = bus.instr[6:0] == OPC_BRANCH;
    assign w_jal   = bus.instr[6:0] == OPC_JAL;
    assign w_jalr  = bus.instr[6:0] == OPC_JALR;
    assign w_lui   = bus.instr[6:0] == OPC_LUI;
    assign w_op    = bus.instr[6:0] == OPC_OP;
    assign w_opi   = bus.instr[6:0] == OPC_OPIMM;
    assign w_legal = w_ld | w_st | w_br | w_jal | w_jalr | w_lui | w_op | w_opi;

    assign w_imm   = w_st ? 3'd1 : w_br ? 3'd2 : w_jal ? 3'd3 : w_lui ? 3'd4 : 3'd0;
    assign w_srcb  = w_jalr | w_opi | w_ld | w_st;
    // Only shifts use instr[30] as an ALU modifier on the immediate path.
    assign w_aluop = w_br  ? 4'b1000 :
                     w_op  ? {bus.instr[30], w_f3} :
                     w_opi ? {(w_f3 == 3'b101) & bus.instr[30], w_f3} : 4'b0000;

    assign w_br_bad  = w_f3[2:1] == 2'b01;
    assign w_taken   = w_f3[0] ^ (w_f3[2] ? (w_f3[1] ? bus.ltu : bus.lt) : bus.zero);
    assign w_wait    = (r_state == S_FETCH) | (r_state == S_MEM);
    assign w_ready   = (r_state == S_FETCH) ? bus.imem_ready : bus.dmem_ready;
    // A ready on the final allowed cycle wins over the timeout.
    assign w_timeout = w_wait & ~w_ready & (({1'b0, r_cnt} + 9'd1) >= LIMIT);

    always_comb begin
        w_next = S_TRAP;
        case (r_state)
            S_FETCH:  w_next = w_timeout ? S_TRAP : bus.imem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
            S_EXEC:   w_next = w_br ? (w_br_bad ? S_TRAP : S_FETCH) :
                               (w_jal | w_jalr | w_lui) ? S_FETCH :
                               (w_op | w_opi) ? S_WB :
                               (w_ld | w_st) ? S_MEM : S_TRAP;
            S_MEM:    w_next = (~(w_ld | w_st) | w_timeout) ? S_TRAP :
                               ~bus.dmem_ready ? S_MEM : w_st ? S_FETCH : S_WB;
            S_WB:     w_next = S_FETCH;
            default:  w_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_next != r_state) ? 8'd0 : (w_wait & ~w_ready) ? r_cnt + 8'd1 : r_cnt;
        end
    end

    // Outputs are gated by rst_n so nothing leaks out while reset is held.
    always_comb begin
        bus.imem_req  = 1'b0;
        bus.dmem_req  = 1'b0;
        bus.dmem_we   = 1'b0;
        bus.ir_we     = 1'b0;
        bus.pc_we     = 1'b0;
        bus.pc_src    = 2'd0;
        bus.imm_type  = 3'd0;
        bus.alu_src_b = 1'b0;
        bus.alu_op    = 4'd0;
        bus.reg_we    = 1'b0;
        bus.wb_sel    = 2'd0;
        bus.trap      = 1'b0;
        bus.state_o   = r_state;
        if (rst_n) begin
            case (r_state)
                S_FETCH: begin
                    bus.imem_req = 1'b1;
                    bus.ir_we    = bus.imem_ready;
                end
                S_DECODE: bus.imm_type = w_imm;
                S_EXEC: begin
                    bus.imm_type  = w_imm;
                    bus.alu_src_b = w_srcb;
                    bus.alu_op    = w_aluop;
                    if (w_br) begin
                        bus.pc_we  = ~w_br_bad;
                        bus.pc_src = {1'b0, w_taken};
                    end else if (w_jal | w_jalr | w_lui) begin
                        bus.reg_we = 1'b1;
                        bus.wb_sel = w_lui ? 2'd3 : 2'd2;
                        bus.pc_we  = 1'b1;
                        bus.pc_src = w_jal ? 2'd1 : w_jalr ? 2'd2 : 2'd0;
                    end
                end
                S_MEM: begin
                    bus.imm_type  = w_imm;
                    bus.alu_src_b = w_srcb;
                    bus.alu_op    = w_aluop;
                    bus.dmem_req  = 1'b1;
                    bus.dmem_we   = w_st;
                    bus.pc_we     = w_st & bus.dmem_ready;
                end
                S_WB: begin
                    bus.imm_type  = w_imm;
                    bus.alu_src_b = w_srcb;
                    bus.alu_op    = w_aluop;
                    bus.reg_we    = 1'b1;
                    bus.wb_sel    = {1'b0, w_ld};
                    bus.pc_we     = 1'b1;
                end
                S_TRAP: bus.trap = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_mc_control.sv
// tb_rv_mc_control: per-instruction expected output trace built from instruction
// class and memory wait counts, compared cycle by cycle against the sequencer.
module tb_rv_mc_control;
    localparam int LIMIT = 16;
    localparam int C_ILL = 0, C_LD = 1, C_ST = 2, C_BR = 3, C_JAL = 4, C_JALR = 5, C_LUI = 6, C_OP = 7, C_OPI = 8;

    typedef struct packed {
        logic [2:0] st;
        logic       ireq, dreq, dwe, irwe, pcwe;
        logic [1:0] pcsrc;
        logic       rwe;
        logic [1:0] wbs;
        logic [2:0] imm;
        logic       srcb;
        logic [3:0] aluop;
        logic       trap;
    } ov_t;

    typedef struct {
        ov_t  e;
        ov_t  m;
        logic ir;
        logic dr;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    cyc_t q[$];
    logic [2:0] imm_of [9] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd4, 3'd0, 3'd0};
    logic [6:0] opcs [9] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
                             7'b0110111, 7'b0110011, 7'b0010011, 7'b1111111};

    rv_mc_control_if bus ();

    rv_mc_control #(.WAIT_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ov_t obs();
        ov_t o;
        o.st = bus.state_o;   o.ireq = bus.imem_req; o.dreq = bus.dmem_req;
        o.dwe = bus.dmem_we;  o.irwe = bus.ir_we;    o.pcwe = bus.pc_we;
        o.pcsrc = bus.pc_src; o.rwe = bus.reg_we;    o.wbs = bus.wb_sel;
        o.imm = bus.imm_type; o.srcb = bus.alu_src_b; o.aluop = bus.alu_op;
        o.trap = bus.trap;
        return o;
    endfunction

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c.e = '0; c.m = '1;
        c.m.pcsrc = '0; c.m.wbs = '0; c.m.imm = '0; c.m.srcb = 1'b0; c.m.aluop = '0;
        c.e.st = st; c.ir = 1'b0; c.dr = 1'b0;
        return c;
    endfunction

    task automatic push_trap();
        cyc_t c;
        for (int k = 0; k < 3; k++) begin
            c = blank(3'd5); c.e.trap = 1'b1; c.ir = k[0]; c.dr = 1'b1;
            q.push_back(c);
        end
    endtask

    // Expected trace: fetch waits, decode, execute, optional memory waits, write-back.
    task automatic build(input logic [31:0] ins, input logic z, l, lu, input int wi, wd);
        cyc_t c, h;
        int cls;
        logic [2:0] f3;
        logic taken;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0000011: cls = C_LD;
            7'b0100011: cls = C_ST;
            7'b1100011: cls = C_BR;
            7'b1101111: cls = C_JAL;
            7'b1100111: cls = C_JALR;
            7'b0110111: cls = C_LUI;
            7'b0110011: cls = C_OP;
            7'b0010011: cls = C_OPI;
            default:    cls = C_ILL;
        endcase
        case (f3)
            3'd0: taken = z;
            3'd1: taken = !z;
            3'd4: taken = l;
            3'd5: taken = !l;
            3'd6: taken = lu;
            default: taken = !lu;
        endcase
        h = blank(3'd0);
        h.e.imm = imm_of[cls]; h.m.imm = '1;
        if (cls inside {C_BR, C_JALR, C_LD, C_ST, C_OP, C_OPI}) begin
            h.m.srcb = 1'b1; h.m.aluop = '1;
            h.e.srcb = cls inside {C_JALR, C_LD, C_ST, C_OPI};
            h.e.aluop = (cls == C_BR) ? 4'b1000 : (cls == C_OP) ? {ins[30], f3} :
                        (cls == C_OPI) ? {f3 == 3'd5 && ins[30], f3} : 4'b0000;
        end
        for (int k = 0; k < LIMIT; k++) begin
            c = blank(3'd0); c.e.ireq = 1'b1; c.e.irwe = (k == wi); c.ir = (k == wi);
            q.push_back(c);
            if (k == wi) break;
        end
        if (wi >= LIMIT) begin push_trap(); return; end
        c = h; c.e.st = 3'd1; c.m.srcb = 1'b0; c.m.aluop = '0;
        if (cls == C_ILL) c.m.imm = '0;
        q.push_back(c);
        if (cls == C_ILL) begin push_trap(); return; end
        c = h; c.e.st = 3'd2;
        if (cls == C_BR) begin
            if (f3 == 3'd2 || f3 == 3'd3) begin q.push_back(c); push_trap(); return; end
            c.e.pcwe = 1'b1; c.e.pcsrc = taken ? 2'd1 : 2'd0; c.m.pcsrc = '1;
            q.push_back(c);
            return;
        end
        if (cls inside {C_JAL, C_JALR, C_LUI}) begin
            c.e.rwe = 1'b1; c.e.wbs = (cls == C_LUI) ? 2'd3 : 2'd2; c.m.wbs = '1;
            c.e.pcwe = 1'b1; c.e.pcsrc = (cls == C_JAL) ? 2'd1 : (cls == C_JALR) ? 2'd2 : 2'd0;
            c.m.pcsrc = '1;
            q.push_back(c);
            return;
        end
        q.push_back(c);
        if (cls inside {C_LD, C_ST}) begin
            for (int k = 0; k < LIMIT; k++) begin
                c = h; c.e.st = 3'd3; c.e.dreq = 1'b1; c.e.dwe = (cls == C_ST); c.dr = (k == wd);
                if (k == wd && cls == C_ST) begin c.e.pcwe = 1'b1; c.e.pcsrc = 2'd0; c.m.pcsrc = '1; end
                q.push_back(c);
                if (k == wd) break;
            end
            if (wd >= LIMIT) begin push_trap(); return; end
            if (cls == C_ST) return;
        end
        c = h; c.e.st = 3'd4; c.e.rwe = 1'b1; c.e.wbs = (cls == C_LD) ? 2'd1 : 2'd0; c.m.wbs = '1;
        c.e.pcwe = 1'b1; c.e.pcsrc = 2'd0; c.m.pcsrc = '1;
        q.push_back(c);
    endtask

    task automatic do_reset(input string nm);
        rst_n = 1'b0; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        #1 check({nm, "_rst_outs"}, 32'(obs()), 32'd0);
        @(negedge clk);
        check({nm, "_rst_hold"}, 32'(obs()), 32'd0);
        rst_n = 1'b1;
    endtask

    // Entered and left on a falling edge; each cycle drives inputs then samples 1ns later.
    task automatic run(input string nm, input logic [31:0] ins, input logic z, l, lu,
                       input int wi, wd, input int stop);
        q.delete();
        build(ins, z, l, lu, wi, wd);
        for (int i = 0; i < q.size(); i++) begin
            if (stop > 0 && i >= stop) break;
            bus.instr = ins; bus.zero = z; bus.lt = l; bus.ltu = lu;
            bus.imem_ready = q[i].ir; bus.dmem_ready = q[i].dr;
            #1 check($sformatf("%s_c%0d", nm, i), 32'(obs() & q[i].m), 32'(q[i].e & q[i].m));
            @(negedge clk);
        end
        if (stop == 0 && q[q.size()-1].e.st == 3'd5) do_reset(nm);
    endtask

    function automatic int pick_wait();
        int r;
        r = $urandom_range(0, 29);
        return r < 24 ? r % 4 : r < 27 ? LIMIT - 1 : LIMIT;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, f;
        int s;
        rst_n = 1'b0;
        bus.instr = '0; bus.zero = 1'b0; bus.lt = 1'b0; bus.ltu = 1'b0;
        bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 check("reset_outs", 32'(obs()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("addi", 32'h00500093, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run("lw_wait3", 32'h0000A103, 1'b0, 1'b0, 1'b0, 0, 3, 0);
        run("beq_z1", 32'h00208463, 1'b1, 1'b0, 1'b0, 0, 0, 0);
        run("beq_z0", 32'h00208463, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        for (int b = 0; b < 8; b++)
            for (int g = 0; g < 8; g++)
                run($sformatf("br_f%0d_g%0d", b, g), 32'h00208463 | (32'(b) << 12),
                    g[0], g[1], g[2], 0, 0, 0);
        run("fetch_last_ok", 32'h00500093, 1'b0, 1'b0, 1'b0, LIMIT - 1, 0, 0);
        run("fetch_timeout", 32'h00500093, 1'b0, 1'b0, 1'b0, LIMIT, 0, 0);
        run("sw_last_ok", 32'h0020A023, 1'b0, 1'b0, 1'b0, 1, LIMIT - 1, 0);
        run("lw_timeout", 32'h0000A103, 1'b0, 1'b0, 1'b0, 0, LIMIT, 0);
        run("illegal", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        run("lw_rst", 32'h0000A103, 1'b0, 1'b0, 1'b0, 0, 10, 5);
        #1 check("mem_dreq_pre", 32'(bus.dmem_req), 32'd1);
        rst_n = 1'b0;
        #1 check("mem_dreq_rst", 32'(bus.dmem_req), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run("after_rst", 32'h40F0D093, 1'b0, 1'b0, 1'b0, 0, 0, 0);
        for (int n = 0; n < 300; n++) begin
            r = $urandom();
            f = $urandom();
            s = $urandom_range(0, 9);
            r[6:0] = (s == 9) ? f[13:7] : opcs[s];
            run($sformatf("rnd%0d", n), r, f[0], f[1], f[2], pick_wait(), pick_wait(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
